// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage : fetch_pkg

// File: rtl/fetch_next_pc.sv
// Next-PC priority select (halt > redirect > stall > sequential) and IF/ID
// load/flush enables for the fetch stage; purely combinational.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  fetch_state_t    state_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_req_i,
    output logic [XLEN-1:0] pc_next_c_o,
    output logic [XLEN-1:0] pc_plus4_c_o,
    output logic            ifid_load_c_o,
    output logic            ifid_flush_c_o
);

    // Sequential increment wraps modulo 2^XLEN.
    assign pc_plus4_c_o = pc_i + XLEN'(PC_INC);

    always_comb begin
        pc_next_c_o    = pc_i;
        ifid_load_c_o  = 1'b0;
        ifid_flush_c_o = 1'b0;
        if (state_i == RUN) begin
            if (halt_req_i) begin
                ifid_flush_c_o = 1'b1;
            end else if (redirect_valid_i) begin
                pc_next_c_o    = redirect_pc_i & ~XLEN'(~ALIGN_MASK);
                ifid_flush_c_o = 1'b1;
            end else if (!stall_i) begin
                pc_next_c_o   = pc_plus4_c_o;
                ifid_load_c_o = 1'b1;
            end
        end
    end

endmodule : fetch_next_pc

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register and BOOT/RUN/HALTED FSM.
// Optional fetch/flush counters are built when FETCH_STATS_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_dout,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_inst,
    output logic [XLEN-1:0] ifid_pc_plus4,
`ifdef FETCH_STATS_EN
    output logic [31:0]     fetch_count,
    output logic [31:0]     flush_count,
`endif
    output logic            fetch_halted
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;
    logic [XLEN-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic            fetch_halted_q, fetch_halted_d;

    logic [XLEN-1:0] pc_plus4_c;
    logic            ifid_load_c;
    logic            ifid_flush_c;

    fetch_next_pc #(
        .XLEN(XLEN)
    ) u_next_pc (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .stall_i         (stall),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .halt_req_i      (halt_req),
        .pc_next_c_o     (pc_d),
        .pc_plus4_c_o    (pc_plus4_c),
        .ifid_load_c_o   (ifid_load_c),
        .ifid_flush_c_o  (ifid_flush_c)
    );

    // Next state and IF/ID register contents.
    always_comb begin
        state_d         = state_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;

        unique case (state_q)
            BOOT:    state_d = halt_req ? HALTED : RUN;
            RUN:     if (halt_req) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase

        if (ifid_load_c) begin
            ifid_valid_d    = 1'b1;
            ifid_pc_d       = pc_q;
            ifid_inst_d     = imem_dout;
            ifid_pc_plus4_d = pc_plus4_c;
        end else if (ifid_flush_c || state_q != RUN) begin
            ifid_valid_d = 1'b0;
        end

        fetch_halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= BOOT;
            pc_q            <= RESET_PC;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= '0;
            ifid_inst_q     <= '0;
            ifid_pc_plus4_q <= '0;
            fetch_halted_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            fetch_halted_q  <= fetch_halted_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_inst     = ifid_inst_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign fetch_halted  = fetch_halted_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic        redirect_acc_c;

    // A flush in RUN without halt is an accepted redirect.
    assign redirect_acc_c = ifid_flush_c && !halt_req;

    // Saturating counters; enables are only ever raised in RUN.
    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (ifid_load_c && fetch_count_q != 32'hFFFF_FFFF) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (redirect_acc_c && flush_count_q != 32'hFFFF_FFFF) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a hashed-content memory.
// Counter checks are compiled in when FETCH_STATS_EN is defined.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc_plus4;
    logic        fetch_halted;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Memory word stored at a byte address (distinct per address).
    function automatic logic [31:0] w(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_dout = w(imem_addr);

    fetch_stage #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_dout     (imem_dout),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_req),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus4 (ifid_pc_plus4),
`ifdef FETCH_STATS_EN
        .fetch_count   (fetch_count),
        .flush_count   (flush_count),
`endif
        .fetch_halted  (fetch_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        halt;
        logic        exp_valid;
        logic [31:0] exp_ifid_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_plus4;
        logic [31:0] exp_pc;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic h, input logic ev, input logic [31:0] eipc,
                                input logic [31:0] einst, input logic [31:0] ep4,
                                input logic [31:0] epc, input logic eh);
        vec_t v;
        v.stall = s; v.rv = rv; v.rpc = rpc; v.halt = h;
        v.exp_valid = ev; v.exp_ifid_pc = eipc; v.exp_inst = einst;
        v.exp_plus4 = ep4; v.exp_pc = epc; v.exp_halted = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input logic h);
        stall = s; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] eipc,
                           input logic [31:0] einst, input logic [31:0] ep4,
                           input logic [31:0] epc, input logic eh);
        chk({tag, ".valid"},  32'(ifid_valid), 32'(ev));
        chk({tag, ".ifid_pc"}, ifid_pc, eipc);
        chk({tag, ".inst"},   ifid_inst, einst);
        chk({tag, ".plus4"},  ifid_pc_plus4, ep4);
        chk({tag, ".pc"},     imem_addr, epc);
        chk({tag, ".halted"}, 32'(fetch_halted), 32'(eh));
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; halt_req = 1'b0;

        // BOOT ignores stall/redirect, then sequential fetch from 0.
        vecs.push_back(mk(1, 1, 32'h80, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'h0, w(32'h0), 32'h4, 32'h4, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'h4, w(32'h4), 32'h8, 32'h8, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 0, 32'h0, 0, 1, 32'h4, w(32'h4), 32'h8, 32'h8, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'h8, w(32'h8), 32'hC, 32'hC, 0));
        // Redirect beats stall, then aligned redirect target.
        vecs.push_back(mk(1, 1, 32'h40, 0, 0, 32'h8, w(32'h8), 32'hC, 32'h40, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'h40, w(32'h40), 32'h44, 32'h44, 0));
        vecs.push_back(mk(0, 1, 32'h43, 0, 0, 32'h40, w(32'h40), 32'h44, 32'h40, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'h40, w(32'h40), 32'h44, 32'h44, 0));
        // PC wrap at the top of the address space.
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h40, w(32'h40), 32'h44, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC), 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 32'h0, w(32'h0), 32'h4, 32'h4, 0));
        // Halt beats redirect; stays frozen afterward.
        vecs.push_back(mk(0, 1, 32'h100, 1, 0, 32'h0, w(32'h0), 32'h4, 32'h4, 1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(i[0], 1, 32'h200, i[1], 0, 32'h0, w(32'h0), 32'h4, 32'h4, 1));

        // Reset state.
        step(0, 0, 32'h0, 0);
        step(1, 1, 32'h80, 1);
        chk_all("reset", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);

        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].halt);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ifid_pc,
                    vecs[i].exp_inst, vecs[i].exp_plus4, vecs[i].exp_pc, vecs[i].exp_halted);
        end

        // Reset while halted with other inputs active.
        reset = 1'b0;
        step(1, 1, 32'h300, 1);
        chk_all("rst_halted", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        // Halt request during BOOT goes straight to HALTED.
        reset = 1'b1;
        step(0, 0, 32'h0, 1);
        chk_all("boot_halt", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
        step(0, 1, 32'h500, 0);
        chk_all("boot_halt_hold", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1);

        // Reset mid-redirect, then BOOT and first fetch again.
        reset = 1'b0;
        step(0, 1, 32'h600, 0);
        reset = 1'b1;
        step(0, 0, 32'h0, 0);
        chk_all("reboot", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        chk_all("reboot_fetch", 1, 32'h0, w(32'h0), 32'h4, 32'h4, 0);

`ifdef FETCH_STATS_EN
        reset = 1'b0;
        step(0, 0, 32'h0, 0);
        chk("cnt_rst_fetch", fetch_count, 32'd0);
        chk("cnt_rst_flush", flush_count, 32'd0);
        reset = 1'b1;
        step(0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
        step(0, 1, 32'h20, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 32'h0, 0);
        step(1, 1, 32'h60, 0);
        step(1, 0, 32'h0, 0);
        chk("cnt_fetch", fetch_count, 32'd5);
        chk("cnt_flush", flush_count, 32'd2);
        reset = 1'b0;
        step(1, 0, 32'h0, 0);
        chk("cnt_fetch_clr", fetch_count, 32'd0);
        chk("cnt_flush_clr", flush_count, 32'd0);
        chk_all("cnt_rst", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        reset = 1'b1;
        step(0, 1, 32'h80, 0);
        chk("cnt_boot_fetch", fetch_count, 32'd0);
        chk("cnt_boot_flush", flush_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined core with always-not-taken branch prediction.
- Owns the PC register and drives the address into the asynchronous-read instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Handles hazard-unit stalls, EX-stage mispredict redirects (flush) and the terminating halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, PC and instruction width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk; asserted when 0.
- imem_addr  output  XLEN  byte address to instruction memory; combinational copy of pc.
- imem_dout  input  XLEN  instruction word returned combinationally for imem_addr.
- stall  input  1  hazard-unit stall; hold PC and IF/ID.
- redirect_valid  input  1  EX-stage mispredict or jump.
- redirect_pc  input  XLEN  corrected target.
- halt_req  input  1  halt instruction reached a later stage.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_pc  output  XLEN  PC of the IF/ID instruction.
- ifid_inst  output  XLEN  instruction word in IF/ID.
- ifid_pc_plus4  output  XLEN  ifid_pc + 4.
- fetch_halted  output  1  stage is in HALTED.

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_PC, state=BOOT.
  - ifid_valid=0, ifid_pc=0, ifid_inst=0, ifid_pc_plus4=0, fetch_halted=0.
  - Reset overrides every other input.
- imem_addr=pc at all times, no latency.
- States: BOOT, RUN, HALTED.
- BOOT:
  - Exactly one cycle after reset is released. Instruction memory contents are valid from this cycle onward.
  - No IF/ID load; ifid_valid stays 0; pc held.
  - stall and redirect_valid are ignored. halt_req goes to HALTED; otherwise go to RUN.
- RUN: priority per posedge is halt_req > redirect_valid > stall > normal.
  - halt_req:
    - state=HALTED, ifid_valid=0, pc held.
    - fetch_halted=1 from the next cycle.
  - redirect_valid:
    - pc=redirect_pc with bits[1:0] forced to 0.
    - ifid_valid=0 (flush); other IF/ID fields unchanged.
    - Overrides stall in the same cycle.
  - stall: pc and all IF/ID fields hold, including ifid_valid.
  - normal:
    - pc=pc+4.
    - ifid_valid=1, ifid_pc=pc, ifid_inst=imem_dout, ifid_pc_plus4=pc+4.
- HALTED:
  - Absorbing until reset. pc frozen; ifid_valid=0.
  - All inputs except reset are ignored.
- Arithmetic:
  - pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no error.
- Latency:
  - An instruction at pc appears on ifid_* one posedge after it is presented.
  - A redirect's first instruction appears two posedges after redirect_valid is sampled.
- Reset in the middle of a stall, redirect or halt: reset wins, and the block re-enters BOOT.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - Adds output fetch_count (32) and output flush_count (32).
  - fetch_count increments on each normal IF/ID load.
  - flush_count increments on each accepted redirect in RUN.
  - Both saturate at 32'hFFFF_FFFF and clear on reset. Both are frozen in BOOT and HALTED.
- Undefined: ports and counters are absent; remaining behaviour is identical.

Decomposition:
- Package fetch_pkg contains:
  - fetch_state_t enum {BOOT, RUN, HALTED}.
  - DEFAULT_RESET_PC.
  - PC_INC=4.
  - ALIGN_MASK=32'hFFFF_FFFC.
- One sub-module, fetch_next_pc: combinational priority select of next pc and IF/ID load/flush enables. The top module holds the registers and the FSM.

Test Plan:
- Reset release with RESET_PC=0 and memory words at 0x0/0x4/0x8:
  - ifid_valid=0 during BOOT.
  - Then on consecutive cycles, ifid_pc is 0x0, 0x4, 0x8, with the matching words in ifid_inst.
- stall held high for 3 cycles while ifid_pc=0x4: pc=0x8 and ifid_pc=0x4 are held unchanged for all 3 cycles; fetch resumes with 0x8.
- redirect_valid=1 with redirect_pc=0x40 and stall=1 in the same cycle:
  - Next cycle: ifid_valid=0 and pc=0x40.
  - Cycle after: ifid_pc=0x40.
  - redirect_pc=0x43 yields pc=0x40.
- halt_req and redirect_valid asserted in the same cycle:
  - fetch_halted=1 and ifid_valid=0.
  - pc is unchanged, and it stays frozen for 10 cycles despite further redirects.
- Force pc to 0xFFFF_FFFC via redirect: next pc=0x0 and ifid_pc_plus4=0x0.
- With FETCH_STATS_EN, after 5 loads, 2 redirects and a reset mid-stall:
  - Before reset: fetch_count=5, flush_count=2.
  - After reset: both counters 0, state BOOT.
